// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the nibble-serial 74181 sequencer.
package alu_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  function automatic int nibbles(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Runs a DATA_WIDTH-bit 74181 operation through one 4-bit slice, LSB nibble first; done NIBBLES+1 cycles after start.
// Optional ALU_SEQ_COLLISION_EN adds a sticky start_err flag for start-while-busy, cleared by clr_err.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            s,
  input  logic                  m,
  input  logic                  cn,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] f,
  output logic                  cout,
  output logic                  equal,
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic [3:0]            alu_s,
  output logic                  alu_m,
  output logic                  alu_cn,
  input  logic [3:0]            alu_f,
  input  logic                  alu_cn4,
  input  logic                  alu_equal
`ifdef ALU_SEQ_COLLISION_EN
  ,
  input  logic                  clr_err,
  output logic                  start_err
`endif
);

  localparam int NIBBLES = nibbles(DATA_WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  seq_state_t                      state;
  logic [IDX_W-1:0]                idx;
  logic [NIBBLES-1:0][SLICE_W-1:0] a_q, b_q, res_q, res_nx;
  logic [3:0]                      s_q;
  logic                            m_q, cn_q, carry_q, eq_acc;

  always_comb begin
    res_nx      = res_q;
    res_nx[idx] = alu_f;
  end

  // Outside RUN the slice still sees nibble 0 and the latched carry-in, never floating values.
  assign alu_a  = (state == RUN) ? a_q[idx] : a_q[0];
  assign alu_b  = (state == RUN) ? b_q[idx] : b_q[0];
  assign alu_cn = (state == RUN) ? carry_q  : cn_q;
  assign alu_s  = s_q;
  assign alu_m  = m_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      cn_q    <= 1'b0;
      carry_q <= 1'b1;
      eq_acc  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= '0;
      cout    <= 1'b1;
      equal   <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            cn_q    <= cn;
            carry_q <= cn;
            idx     <= '0;
            eq_acc  <= 1'b1;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_nx;
          carry_q <= alu_cn4;
          eq_acc  <= eq_acc & alu_equal;
          if (idx == LAST_IDX) begin
            f     <= res_nx;
            cout  <= alu_cn4;
            equal <= eq_acc & alu_equal;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_COLLISION_EN
  // A collision in the same cycle as a clear still leaves the flag set.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      start_err <= 1'b0;
    end else if (ena) begin
      if (start && busy) begin
        start_err <= 1'b1;
      end else if (clr_err) begin
        start_err <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 74181 slice on the alu_* ports.
module tb_alu_nibble_sequencer;

  localparam int DW  = 8;
  localparam int NIB = DW / 4;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          ena = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0, b = '0;
  logic [3:0]    s = '0;
  logic          m = 1'b0, cn = 1'b1;
  logic          busy, done, cout, equal;
  logic [DW-1:0] f;
  logic [3:0]    alu_a, alu_b, alu_s, alu_f;
  logic          alu_m, alu_cn, alu_cn4, alu_equal;
`ifdef ALU_SEQ_COLLISION_EN
  logic          clr_err = 1'b0;
  logic          start_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start),
    .a(a), .b(b), .s(s), .m(m), .cn(cn),
    .busy(busy), .done(done), .f(f), .cout(cout), .equal(equal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_equal(alu_equal)
`ifdef ALU_SEQ_COLLISION_EN
    , .clr_err(clr_err), .start_err(start_err)
`endif
  );

  // 74181 slice, active-high data: arithmetic F = P plus Q plus carry, logic F = ~(P ^ Q).
  logic [3:0] sl_p, sl_q, sl_f;
  logic [4:0] sl_sum;
  always_comb begin
    sl_p      = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    sl_q      = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    sl_sum    = {1'b0, sl_p} + {1'b0, sl_q} + {4'b0, ~alu_cn};
    sl_f      = alu_m ? ~(sl_p ^ sl_q) : sl_sum[3:0];
    alu_f     = sl_f;
    alu_cn4   = ~sl_sum[4];
    alu_equal = (sl_f == 4'hF);
  end

  typedef struct {
    logic [DW-1:0] a, b;
    logic [3:0]    s;
    logic          m, cn;
    logic [DW-1:0] ef;
    logic          ec, ee;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Starts an operation at the next falling edge; returns at the first RUN cycle.
  task automatic launch(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [3:0] vs, input logic vm, input logic vcn);
    @(negedge clk);
    a = va; b = vb; s = vs; m = vm; cn = vcn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;

    vt[0] = '{8'h3C, 8'h55, 4'b1001, 1'b0, 1'b1, 8'h91, 1'b1, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[2] = '{8'h77, 8'h77, 4'b0110, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1};
    vt[3] = '{8'h77, 8'h76, 4'b0110, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hF0, 8'hAA, 4'b0110, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[5] = '{8'h12, 8'h34, 4'b1001, 1'b0, 1'b0, 8'h47, 1'b1, 1'b0};
    vt[6] = '{8'h0F, 8'h00, 4'b0000, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0};
    vt[7] = '{8'h5A, 8'h3C, 4'b0011, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[8] = '{8'h81, 8'h00, 4'b1100, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};
    vt[9] = '{8'hFF, 8'h00, 4'b1111, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_f", {24'b0, f}, 32'h00);
    check("rst_cout", {31'b0, cout}, 32'd1);
    check("rst_equal", {31'b0, equal}, 32'd0);
    check("rst_alu_a", {28'b0, alu_a}, 32'h0);
`ifdef ALU_SEQ_COLLISION_EN
    check("rst_start_err", {31'b0, start_err}, 32'd0);
`endif
    rstb = 1'b1;

    // Cycle-by-cycle add: internal nibble carry visible on alu_cn
    launch(8'h3C, 8'h55, 4'b1001, 1'b0, 1'b1);
    check("add_run0_busy", {31'b0, busy}, 32'd1);
    check("add_run0_alu_a", {28'b0, alu_a}, 32'hC);
    check("add_run0_alu_b", {28'b0, alu_b}, 32'h5);
    check("add_run0_alu_cn", {31'b0, alu_cn}, 32'd1);
    check("add_run0_alu_s", {28'b0, alu_s}, 32'h9);
    @(negedge clk);
    check("add_run1_alu_a", {28'b0, alu_a}, 32'h3);
    check("add_run1_alu_cn", {31'b0, alu_cn}, 32'd0);
    check("add_run1_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("add_done", {31'b0, done}, 32'd1);
    check("add_f", {24'b0, f}, 32'h91);
    check("add_cout", {31'b0, cout}, 32'd1);
    @(negedge clk);
    check("add_done_pulse", {31'b0, done}, 32'd0);
    check("add_idle_busy", {31'b0, busy}, 32'd0);
    check("add_f_held", {24'b0, f}, 32'h91);
    check("add_idle_alu_a", {28'b0, alu_a}, 32'hC);

    // Table vectors, back-to-back, with inputs scrambled after acceptance
    for (int i = 0; i < 10; i++) begin
      launch(vt[i].a, vt[i].b, vt[i].s, vt[i].m, vt[i].cn);
      a = ~vt[i].a; b = ~vt[i].b; s = ~vt[i].s; m = ~vt[i].m; cn = ~vt[i].cn;
      wait_done(1, cyc);
      check($sformatf("vec%0d_latency", i), cyc, NIB + 1);
      check($sformatf("vec%0d_f", i), {24'b0, f}, {24'b0, vt[i].ef});
      check($sformatf("vec%0d_cout", i), {31'b0, cout}, {31'b0, vt[i].ec});
      check($sformatf("vec%0d_equal", i), {31'b0, equal}, {31'b0, vt[i].ee});
    end

    // Collision: start mid-RUN with new operands must not disturb the result
    launch(8'hF0, 8'hAA, 4'b0110, 1'b1, 1'b1);
    a = 8'h00; b = 8'h00; s = 4'b1001;
    start = 1'b1;
`ifdef ALU_SEQ_COLLISION_EN
    clr_err = 1'b1;
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef ALU_SEQ_COLLISION_EN
    clr_err = 1'b0;
    check("coll_set_wins", {31'b0, start_err}, 32'd1);
`endif
    wait_done(2, cyc);
    check("coll_latency", cyc, NIB + 1);
    check("coll_f", {24'b0, f}, 32'h5A);
`ifdef ALU_SEQ_COLLISION_EN
    @(negedge clk);
    check("coll_err_sticky", {31'b0, start_err}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("coll_err_cleared", {31'b0, start_err}, 32'd0);
`endif

    // Stall: ena low for 3 cycles in RUN, then a stretched done pulse
    launch(8'h3C, 8'h55, 4'b1001, 1'b0, 1'b1);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_busy", {31'b0, busy}, 32'd1);
    ena = 1'b1;
    wait_done(4, cyc);
    check("stall_latency", cyc, NIB + 4);
    check("stall_f", {24'b0, f}, 32'h91);
    ena = 1'b0;
    @(negedge clk);
    check("stretch_done1", {31'b0, done}, 32'd1);
    @(negedge clk);
    check("stretch_done2", {31'b0, done}, 32'd1);
    ena = 1'b1;
    @(negedge clk);
    check("stretch_end", {31'b0, done}, 32'd0);

    // Reset mid-RUN discards the partial result
    launch(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_f", {24'b0, f}, 32'h00);
    check("midrst_cout", {31'b0, cout}, 32'd1);
    check("midrst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    launch(8'h12, 8'h34, 4'b1001, 1'b0, 1'b0);
    wait_done(1, cyc);
    check("postrst_latency", cyc, NIB + 1);
    check("postrst_f", {24'b0, f}, 32'h47);
    check("postrst_cout", {31'b0, cout}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
